// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes, 4KB burst boundary and the BRAM-to-AXI FSM states.
package axi_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   localparam int unsigned BOUNDARY_4K = 4096;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } b2a_state_e;

endpackage

// File: rtl/axi_bram2axi_if.sv
// AXI4 write-channel bundle (AW/W/B) between the BRAM-to-AXI engine and host memory.
interface axi_bram2axi_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 128
);
   logic                  awvalid;
   logic                  awready;
   logic [ADDR_W-1:0]     awaddr;
   logic [7:0]            awlen;
   logic                  wvalid;
   logic                  wready;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  wlast;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;

   modport master (
      output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
      input  awready, wready, bvalid, bresp
   );

   modport slave (
      input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
      output awready, wready, bvalid, bresp
   );
endinterface

// File: rtl/axi_bram2axis_rd.sv
// BRAM prefetch reader: issues sequential reads from word 0, absorbs fixed read latency,
// buffers words in a small FIFO and presents them as a valid/ready stream.
module axi_bram2axis_rd
   import axi_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 128,
   parameter int unsigned XW         = 32,
   parameter int unsigned DELAY      = 2,
   parameter int unsigned DEPTH      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [XW-1:0]     load_beats,
   input  logic              bram_ready,
   output logic              rden,
   output logic [ADDR_W-1:0] rdaddr,
   input  logic [DATA_W-1:0] rddata,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [XW-1:0]     reads_left;
   logic [ADDR_W-1:0] rd_addr;
   logic [CNT_W-1:0]  pend;
   logic [CNT_W-1:0]  fifo_cnt;
   logic [DELAY-1:0]  pipe;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              push;
   logic              pop;
   logic              rden_c;

   // Reads in flight are reserved FIFO slots, so the buffer can never overflow.
   assign rden_c  = bram_ready && (reads_left != '0) &&
                    (((CNT_W+1)'(fifo_cnt) + (CNT_W+1)'(pend)) < (CNT_W+1)'(DEPTH));
   assign push    = pipe[DELAY-1];
   assign pop     = m_ready && (fifo_cnt != '0);
   assign rden    = rden_c;
   assign rdaddr  = rd_addr;
   assign m_valid = (fifo_cnt != '0);
   assign m_data  = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reads_left <= '0;
         rd_addr    <= '0;
         pend       <= '0;
         fifo_cnt   <= '0;
         pipe       <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else if (load) begin
         reads_left <= load_beats;
         rd_addr    <= '0;
         pend       <= '0;
         fifo_cnt   <= '0;
         pipe       <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         if (rden_c) begin
            reads_left <= reads_left - XW'(1);
            rd_addr    <= rd_addr + ADDR_W'(1);
         end
         pipe     <= (pipe << 1) | DELAY'(rden_c);
         pend     <= pend + CNT_W'(rden_c) - CNT_W'(push);
         fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
         if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rddata;
   end
endmodule

// File: rtl/axi_bram2axi.sv
// Streams BRAM words 0..beats-1 to host memory as 4KB-safe AXI4 write bursts.
// Optional AXI_B2A_BRESP_CHK_EN: sticky o_b2a_error on any non-OKAY write response.
module axi_bram2axi
   import axi_pkg::*;
#(
   parameter int unsigned AXI_ADDR_WIDTH      = 64,
   parameter int unsigned AXI_DATA_WIDTH      = 128,
   parameter int unsigned AXI_XFER_SIZE_WIDTH = 32,
   parameter int unsigned BRAM_ADDR_WIDTH     = 32,
   parameter int unsigned BRAM_DATA_WIDTH     = 128,
   parameter int unsigned BRAM_DELAY          = 2,
   parameter int unsigned MAX_BURST_LEN       = 64,
   parameter int unsigned MAX_OUTSTANDING     = 4,
   parameter int unsigned FIFO_DEPTH          = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_b2a_start,
   output logic                           o_b2a_done,
   output logic                           o_b2a_busy,
   input  logic                           i_b2a_ready,
   input  logic [AXI_ADDR_WIDTH-1:0]      i_b2a_data_addr,
   input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_b2a_data_size_bytes,
   output logic                           o_b2a_error,
   axi_bram2axi_if.master                 axi,
   output logic                           o_b2a_rden,
   output logic [BRAM_ADDR_WIDTH-1:0]     o_b2a_rdaddr,
   input  logic [BRAM_DATA_WIDTH-1:0]     i_b2a_rddata
);
   localparam int unsigned BYTES   = AXI_DATA_WIDTH / 8;
   localparam int unsigned BYTE_SH = $clog2(BYTES);
   localparam int unsigned XW      = AXI_XFER_SIZE_WIDTH;
   localparam int unsigned AW      = AXI_ADDR_WIDTH;

   b2a_state_e           state;
   logic                 busy_q, done_q, bready_q;
   logic [AW-1:0]        aw_addr, w_addr, awaddr_q;
   logic [XW-1:0]        aw_left, w_left, aw_cnt, b_cnt, w_bursts;
   logic [7:0]           awlen_q;
   logic                 awvalid_q;
   logic                 w_active;
   logic [8:0]           w_len, w_cnt;
   logic                 wvalid_q, wlast_q;
   logic [BRAM_DATA_WIDTH-1:0] wdata_q;
   logic [BYTES-1:0]     wstrb_q, last_strb;
   logic                 fifo_valid;
   logic [BRAM_DATA_WIDTH-1:0] fifo_data;

   // Beats in the next burst: capped by max length, remaining beats and the 4KB page end.
   function automatic logic [8:0] calc_len(input logic [AW-1:0] a, input logic [XW-1:0] left);
      logic [12:0] to_bound;
      logic [12:0] bnd_beats;
      logic [8:0]  len;
      to_bound  = 13'(BOUNDARY_4K) - {1'b0, a[11:0]};
      bnd_beats = to_bound >> BYTE_SH;
      len       = 9'(MAX_BURST_LEN);
      if (left < XW'(len)) len = 9'(left);
      if (bnd_beats < 13'(len)) len = 9'(bnd_beats);
      return len;
   endfunction

   logic [XW-1:0]        beats_c;
   logic [BYTE_SH-1:0]   rem_c;
   logic [BYTES-1:0]     last_strb_c;
   logic                 start_ok, load_c;
   logic [8:0]           aw_len_c, w_len_c, w_idx_c;
   logic                 w_last_c, w_ok_c, w_ld_c, aw_go_c, aw_hs, b_hs;
   logic [XW-1:0]        outst_c;

   assign beats_c     = XW'(({1'b0, i_b2a_data_size_bytes} + (XW+1)'(BYTES-1)) >> BYTE_SH);
   assign rem_c       = i_b2a_data_size_bytes[BYTE_SH-1:0];
   assign last_strb_c = (rem_c == '0) ? '1 : ~({BYTES{1'b1}} << rem_c);
   assign start_ok    = (state == ST_IDLE) && i_b2a_start;
   assign load_c      = start_ok && (i_b2a_data_size_bytes != '0);

   assign aw_len_c = calc_len(aw_addr, aw_left);
   assign outst_c  = aw_cnt - b_cnt;
   assign aw_go_c  = (state == ST_RUN) && !awvalid_q && (aw_left != '0) &&
                     (outst_c < XW'(MAX_OUTSTANDING));
   assign aw_hs    = awvalid_q && axi.awready;
   assign b_hs     = axi.bvalid && bready_q;

   // W side replays the same split so wlast lines up with the issued AW lengths.
   assign w_len_c  = w_active ? w_len : calc_len(w_addr, w_left);
   assign w_idx_c  = w_active ? w_cnt : 9'd0;
   assign w_last_c = ((w_idx_c + 9'd1) == w_len_c);
   assign w_ok_c   = w_active || (w_bursts < aw_cnt);
   assign w_ld_c   = (state == ST_RUN) && (!wvalid_q || axi.wready) && fifo_valid &&
                     w_ok_c && (w_left != '0);

   axi_bram2axis_rd #(
      .ADDR_W (BRAM_ADDR_WIDTH),
      .DATA_W (BRAM_DATA_WIDTH),
      .XW     (XW),
      .DELAY  (BRAM_DELAY),
      .DEPTH  (FIFO_DEPTH)
   ) u_rd (
      .clk        (clk),
      .rst        (rst),
      .load       (load_c),
      .load_beats (beats_c),
      .bram_ready (i_b2a_ready),
      .rden       (o_b2a_rden),
      .rdaddr     (o_b2a_rdaddr),
      .rddata     (i_b2a_rddata),
      .m_valid    (fifo_valid),
      .m_data     (fifo_data),
      .m_ready    (w_ld_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bready_q  <= 1'b0;
         aw_addr   <= '0;
         w_addr    <= '0;
         awaddr_q  <= '0;
         aw_left   <= '0;
         w_left    <= '0;
         aw_cnt    <= '0;
         b_cnt     <= '0;
         w_bursts  <= '0;
         awlen_q   <= '0;
         awvalid_q <= 1'b0;
         w_active  <= 1'b0;
         w_len     <= '0;
         w_cnt     <= '0;
         wvalid_q  <= 1'b0;
         wlast_q   <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         last_strb <= '0;
      end else begin
         done_q <= 1'b0;
         if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_cnt    <= aw_cnt + XW'(1);
         end
         if (aw_go_c) begin
            awvalid_q <= 1'b1;
            awaddr_q  <= aw_addr;
            awlen_q   <= 8'(aw_len_c - 9'd1);
            aw_addr   <= aw_addr + (AW'(aw_len_c) << BYTE_SH);
            aw_left   <= aw_left - XW'(aw_len_c);
         end
         if (w_ld_c) begin
            wvalid_q <= 1'b1;
            wdata_q  <= fifo_data;
            wlast_q  <= w_last_c;
            wstrb_q  <= (w_left == XW'(1)) ? last_strb : '1;
            w_left   <= w_left - XW'(1);
            if (!w_active) begin
               w_len    <= w_len_c;
               w_bursts <= w_bursts + XW'(1);
               w_addr   <= w_addr + (AW'(w_len_c) << BYTE_SH);
            end
            w_active <= !w_last_c;
            w_cnt    <= w_last_c ? 9'd0 : w_idx_c + 9'd1;
         end else if (wvalid_q && axi.wready) begin
            wvalid_q <= 1'b0;
         end
         if (b_hs) b_cnt <= b_cnt + XW'(1);

         case (state)
            ST_IDLE: begin
               if (i_b2a_start) begin
                  busy_q    <= 1'b1;
                  bready_q  <= 1'b1;
                  aw_addr   <= i_b2a_data_addr;
                  w_addr    <= i_b2a_data_addr;
                  aw_left   <= beats_c;
                  w_left    <= beats_c;
                  aw_cnt    <= '0;
                  b_cnt     <= '0;
                  w_bursts  <= '0;
                  w_active  <= 1'b0;
                  w_cnt     <= '0;
                  last_strb <= last_strb_c;
                  if (i_b2a_data_size_bytes == '0) begin
                     state  <= ST_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state  <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if ((aw_left == '0) && !awvalid_q && (w_left == '0) && !wvalid_q)
                  state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (b_cnt == aw_cnt) begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
               end
            end
            ST_DONE: begin
               state    <= ST_IDLE;
               busy_q   <= 1'b0;
               bready_q <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef AXI_B2A_BRESP_CHK_EN
   logic error_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    error_q <= 1'b0;
      else if (start_ok)                          error_q <= 1'b0;
      else if (b_hs && (axi.bresp != RESP_OKAY))  error_q <= 1'b1;
   end
   assign o_b2a_error = error_q;
`else
   logic unused_bresp;
   assign unused_bresp = ^axi.bresp;
   assign o_b2a_error  = 1'b0;
`endif

   assign o_b2a_done  = done_q;
   assign o_b2a_busy  = busy_q;
   assign axi.awvalid = awvalid_q;
   assign axi.awaddr  = awaddr_q;
   assign axi.awlen   = awlen_q;
   assign axi.wvalid  = wvalid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wstrb_q;
   assign axi.wlast   = wlast_q;
   assign axi.bready  = bready_q;
endmodule

// File: tb/tb_axi_bram2axi.sv
// Directed bench for axi_bram2axi: AXI slave/BRAM models, handshake monitor, burst and data checks.
module tb_axi_bram2axi;
   logic         clk = 1'b0;
   logic         rst;
   logic         start, done, busy, bram_ready, error, rden;
   logic [63:0]  data_addr;
   logic [31:0]  size_bytes, rdaddr;
   logic [127:0] rddata;

   always #5 clk = ~clk;

   axi_bram2axi_if #(.ADDR_W(64), .DATA_W(128)) axi ();

   axi_bram2axi dut (
      .clk                   (clk),
      .rst                   (rst),
      .i_b2a_start           (start),
      .o_b2a_done            (done),
      .o_b2a_busy            (busy),
      .i_b2a_ready           (bram_ready),
      .i_b2a_data_addr       (data_addr),
      .i_b2a_data_size_bytes (size_bytes),
      .o_b2a_error           (error),
      .axi                   (axi),
      .o_b2a_rden            (rden),
      .o_b2a_rdaddr          (rdaddr),
      .i_b2a_rddata          (rddata)
   );

`ifdef AXI_B2A_BRESP_CHK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] bram_word(input logic [31:0] a);
      return {32'hC0DE0000 ^ a, ~a, a + 32'h11, a};
   endfunction

   // BRAM model with two-cycle read latency
   logic [31:0] a1;
   always @(posedge clk) begin
      a1     <= rdaddr;
      rddata <= bram_word(a1);
   end

   logic [63:0]  aw_a_q[$];
   logic [7:0]   aw_l_q[$];
   logic [127:0] wd_q[$];
   logic         wl_q[$];
   logic [15:0]  ws_q[$];
   int aw_seen, b_seen, rd_seen, done_seen, viol, max_out;
   logic aw_wait, w_wait, w_hold_l;
   logic [63:0]  aw_hold_a;
   logic [7:0]   aw_hold_l;
   logic [127:0] w_hold_d;
   int rnd = 0, b_en = 1, bad_idx = -1;

   // Monitor: inputs change just after posedge, so negedge values are those sampled at the next edge
   always @(negedge clk) begin
      if (!rst) begin
         if (aw_wait && (!axi.awvalid || axi.awaddr != aw_hold_a || axi.awlen != aw_hold_l)) viol++;
         if (w_wait && (!axi.wvalid || axi.wdata != w_hold_d || axi.wlast != w_hold_l)) viol++;
         aw_wait = axi.awvalid && !axi.awready;
         aw_hold_a = axi.awaddr; aw_hold_l = axi.awlen;
         w_wait = axi.wvalid && !axi.wready;
         w_hold_d = axi.wdata; w_hold_l = axi.wlast;
         if (axi.awvalid && axi.awready) begin
            aw_a_q.push_back(axi.awaddr); aw_l_q.push_back(axi.awlen); aw_seen++;
         end
         if (axi.wvalid && axi.wready) begin
            wd_q.push_back(axi.wdata); wl_q.push_back(axi.wlast); ws_q.push_back(axi.wstrb);
         end
         if (axi.bvalid && axi.bready) b_seen++;
         if (aw_seen - b_seen > max_out) max_out = aw_seen - b_seen;
         if (rden) begin
            if (!bram_ready || rdaddr != 32'(rd_seen)) viol++;
            rd_seen++;
         end
         if (done) done_seen++;
      end
   end

   always @(posedge clk) begin
      #1;
      axi.awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.wready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bram_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.bvalid  = (b_en != 0) && (aw_seen > b_seen);
      axi.bresp   = (b_seen == bad_idx) ? 2'b10 : 2'b00;
   end

   logic [63:0] ea[16];
   logic [7:0]  el[16];

   task automatic clear_mon();
      aw_a_q.delete(); aw_l_q.delete(); wd_q.delete(); wl_q.delete(); ws_q.delete();
      aw_seen = 0; b_seen = 0; rd_seen = 0; done_seen = 0; viol = 0; max_out = 0;
      aw_wait = 1'b0; w_wait = 1'b0;
   endtask

   task automatic kick(input logic [63:0] addr, input logic [31:0] size);
      @(posedge clk); #1;
      start = 1'b1; data_addr = addr; size_bytes = size;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < budget);
      chk($sformatf("%s_done_seen", tag), done, 1'b1);
   endtask

   task automatic run(input string tag, input logic [63:0] addr, input logic [31:0] size,
                      input int budget, output int n);
      clear_mon();
      kick(addr, size);
      wait_done(tag, budget, n);
      @(negedge clk);
      chk($sformatf("%s_done_pulse", tag), done, 1'b0);
      chk($sformatf("%s_busy_off", tag), busy, 1'b0);
   endtask

   task automatic verify(input string tag, input int n_aw, input int beats, input logic [15:0] lstrb);
      int err, bi, k;
      logic exp_last;
      chk($sformatf("%s_naw", tag), aw_a_q.size(), n_aw);
      for (int i = 0; i < n_aw && i < aw_a_q.size(); i++) begin
         chk($sformatf("%s_awaddr%0d", tag, i), aw_a_q[i], ea[i]);
         chk($sformatf("%s_awlen%0d", tag, i), aw_l_q[i], el[i]);
      end
      chk($sformatf("%s_nbeats", tag), wd_q.size(), beats);
      err = 0; bi = 0; k = 0;
      for (int j = 0; j < wd_q.size(); j++) begin
         exp_last = (bi < 16) && (k == int'(el[bi]));
         if (wd_q[j] != bram_word(32'(j))) err++;
         if (wl_q[j] != exp_last) err++;
         if (ws_q[j] != ((j == beats - 1) ? lstrb : 16'hFFFF)) err++;
         if (exp_last) begin bi++; k = 0; end else k++;
      end
      chk($sformatf("%s_payload_errs", tag), err, 0);
      chk($sformatf("%s_rd_count", tag), rd_seen, beats);
      chk($sformatf("%s_protocol_viol", tag), viol, 0);
      chk($sformatf("%s_done_count", tag), done_seen, 1);
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; data_addr = '0; size_bytes = '0;
      clear_mon();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_awvalid", axi.awvalid, 1'b0);
      chk("rst_wvalid", axi.wvalid, 1'b0);
      chk("rst_bready", axi.bready, 1'b0);
      chk("rst_rden", rden, 1'b0);
      chk("rst_error", error, 1'b0);

      // single 4-beat burst
      ea[0] = 64'h1000; el[0] = 8'd3;
      run("t1", 64'h1000, 32'd64, 500, n);
      verify("t1", 1, 4, 16'hFFFF);
      chk("t1_error", error, 1'b0);

      // split at 4KB page, SLVERR on second burst
      bad_idx = 1;
      ea[0] = 64'h0F80; el[0] = 8'd7; ea[1] = 64'h1000; el[1] = 8'd7;
      run("t2", 64'h0F80, 32'd256, 1000, n);
      verify("t2", 2, 16, 16'hFFFF);
      chk("t2_error", error, EXP_ERR);
      repeat (5) @(negedge clk);
      chk("t2_error_sticky", error, EXP_ERR);
      bad_idx = -1;

      // zero-length transfer: done one cycle after start, no traffic, error cleared
      run("t3", 64'h2000, 32'd0, 20, n);
      chk("t3_done_latency", n, 1);
      chk("t3_error_clr", error, 1'b0);
      chk("t3_naw", aw_seen, 0);
      chk("t3_nbeats", wd_q.size(), 0);
      chk("t3_rd_count", rd_seen, 0);

      // 513 beats with B withheld: outstanding limit stalls AW at 4
      b_en = 0;
      clear_mon();
      kick(64'h0, 32'd8200);
      repeat (400) @(negedge clk);
      chk("t4_stall_naw", aw_seen, 4);
      chk("t4_stall_busy", busy, 1'b1);
      chk("t4_stall_beats", wd_q.size(), 256);
      b_en = 1;
      for (int i = 0; i < 8; i++) begin ea[i] = 64'(i) * 64'h400; el[i] = 8'd63; end
      ea[8] = 64'h2000; el[8] = 8'd0;
      wait_done("t4", 5000, n);
      @(negedge clk);
      verify("t4", 9, 513, 16'h00FF);
      chk("t4_max_outst", max_out, 4);

      // random backpressure on AW, W and BRAM side
      rnd = 1;
      ea[0] = 64'h2FC0; el[0] = 8'd3; ea[1] = 64'h3000; el[1] = 8'd58;
      run("t5", 64'h2FC0, 32'd1000, 5000, n);
      rnd = 0;
      verify("t5", 2, 63, 16'h00FF);

      // reset mid-transfer aborts without done
      clear_mon();
      kick(64'h1000, 32'd64);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("t6_busy", busy, 1'b0);
      chk("t6_awvalid", axi.awvalid, 1'b0);
      chk("t6_wvalid", axi.wvalid, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      clear_mon();
      repeat (10) @(negedge clk);
      chk("t6_no_done", done_seen, 0);
      chk("t6_idle", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
